// File: rtl/avst_pkg.sv
// Shared types and default widths for the Avalon-ST FIFO source.
package avst_pkg;

  localparam int DEF_DATABITS_PER_SYMBOL = 8;
  localparam int DEF_SYMBOLS_PER_BEAT    = 4;
  localparam int DEF_LEN_W               = 16;

  // Depth of the output buffer between the FIFO read port and the source.
  localparam int BUF_DEPTH = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/avst_fifo_src_if.sv
// Avalon-ST source bundle (data plus packet framing).
//
// Handshake: a beat transfers on a rising clock edge where valid=1 and
// ready=1 (readyLatency 0). Once valid is raised it stays high, and data,
// sop, eop and empty stay unchanged, until that transfer happens. ready may
// change freely and never depends combinationally on anything but the sink.
interface avst_fifo_src_if
  import avst_pkg::*;
#(
  parameter int WIDTH   = DEF_DATABITS_PER_SYMBOL * DEF_SYMBOLS_PER_BEAT,
  parameter int EMPTY_W = $clog2(DEF_SYMBOLS_PER_BEAT)
);

  logic [WIDTH-1:0]   data;
  logic               valid;
  logic               ready;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;

  modport master (
    output data, valid, sop, eop, empty,
    input  ready
  );

  modport slave (
    input  data, valid, sop, eop, empty,
    output ready
  );

endinterface

// File: rtl/avst_skid_buf.sv
// Two-entry in-order buffer holding FIFO words until the sink accepts them.
// head is always the oldest entry; count tells how many entries are live.
module avst_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_pop;
  logic         do_push;

  // Next-entry computation; a pop on an empty buffer or a push into a full
  // buffer without a matching pop are ignored so the count can never wrap.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    do_pop  = pop_i && (cnt_q != 2'd0);
    do_push = push_i && ((cnt_q != 2'd2) || do_pop);
    case ({do_push, do_pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = push_data_i;
        else               tail_d = push_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = push_data_i;
        end else begin
          head_d = tail_q;
          tail_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  // Entry storage and occupancy register; reset empties the buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o  = head_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/avst_fifo_src.sv
// Reads one packet of pkt_len_i words from a registered-output FIFO and
// emits it as an Avalon-ST packet with sop/eop/empty framing.
module avst_fifo_src
  import avst_pkg::*;
#(
  parameter int DATABITS_PER_SYMBOL = DEF_DATABITS_PER_SYMBOL,
  parameter int SYMBOLS_PER_BEAT    = DEF_SYMBOLS_PER_BEAT,
  parameter int WIDTH               = DATABITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
  parameter int LEN_W               = DEF_LEN_W
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                start_i,
  input  logic [LEN_W-1:0]                    pkt_len_i,
  input  logic [$clog2(SYMBOLS_PER_BEAT)-1:0] pkt_empty_i,
  output logic                                busy_o,
  output logic                                done_o,
  input  logic [WIDTH-1:0]                    fifo_data_i,
  input  logic                                fifo_empty_i,
  output logic                                fifo_rd_o,
  output logic [WIDTH-1:0]                    src_data_o,
  output logic                                src_valid_o,
  output logic                                src_startofpacket_o,
  output logic                                src_endofpacket_o,
  output logic [$clog2(SYMBOLS_PER_BEAT)-1:0] src_empty_o,
  input  logic                                src_ready_i
);

  localparam int EMPTY_W = $clog2(SYMBOLS_PER_BEAT);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [EMPTY_W-1:0] empty_q, empty_d;
  logic [LEN_W-1:0]   req_cnt_q, req_cnt_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               inflight_q, inflight_d;
  logic               done_q, done_d;

  logic [1:0]         buf_cnt;
  logic [WIDTH-1:0]   buf_data;
  logic               valid;
  logic               pop;
  logic               last_beat;
  logic [2:0]         occupancy;
  logic               rd;

  // Words already read from the FIFO land here one cycle later.
  avst_skid_buf #(
    .W (WIDTH)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (inflight_q),
    .push_data_i (fifo_data_i),
    .pop_i       (pop),
    .data_o      (buf_data),
    .count_o     (buf_cnt)
  );

  // Read issue, counters and FSM next state. A read is only issued when the
  // buffer is guaranteed a free slot for it after counting the word still in
  // flight from last cycle and the beat leaving this cycle.
  always_comb begin
    valid      = (buf_cnt != 2'd0);
    pop        = valid && src_ready_i;
    last_beat  = (beat_cnt_q == (len_q - LEN_W'(1)));
    occupancy  = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    rd         = (state_q == RUN) && !fifo_empty_i && (req_cnt_q < len_q) &&
                 (occupancy < 3'(BUF_DEPTH));

    state_d    = state_q;
    len_d      = len_q;
    empty_d    = empty_q;
    req_cnt_d  = req_cnt_q;
    beat_cnt_d = beat_cnt_q;
    inflight_d = rd;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && (pkt_len_i != '0)) begin
          state_d    = RUN;
          len_d      = pkt_len_i;
          empty_d    = pkt_empty_i;
          req_cnt_d  = '0;
          beat_cnt_d = '0;
        end
      end
      RUN: begin
        if (rd)  req_cnt_d  = req_cnt_q + LEN_W'(1);
        if (pop) begin
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
          if (last_beat) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      empty_q    <= '0;
      req_cnt_q  <= '0;
      beat_cnt_q <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      empty_q    <= empty_d;
      req_cnt_q  <= req_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

  // Source outputs; framing derives from the accepted-beat count, which only
  // moves on a transfer, so it holds steady while the sink stalls.
  always_comb begin
    src_valid_o         = valid;
    src_data_o          = valid ? buf_data : '0;
    src_startofpacket_o = valid && (beat_cnt_q == '0);
    src_endofpacket_o   = valid && last_beat;
    src_empty_o         = (valid && last_beat) ? empty_q : '0;
  end

  assign busy_o    = (state_q == RUN);
  assign done_o    = done_q;
  assign fifo_rd_o = rd;

endmodule
